bcd_sub_serial: RTL

- Digit-serial packed-BCD subtractor: computes D = A - B - bin over DIGITS decimal digits, one digit per clock, LSB digit first.
- Inverse operation of the team's combinational decimal-corrected 4-bit adder.
- Sits between the BCD arithmetic datapath and its consumers.
- Valid/ready handshake on both input and output sides.

---
 rtl/bcd_sub_serial_if.sv | 49 ++++
 rtl/bcd_sub_serial.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bcd_sub_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_sub_serial_if
// Description : Handshake/data bundle for the digit-serial BCD subtractor.
//               Input side : in_valid / in_ready carrying a, b, bin.
//               Output side: out_valid / out_ready carrying d, bout
//               (plus err when BCD_SUB_CHECK_EN is defined).
//               master = producer/consumer side, slave = subtractor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_sub_serial_if #(
    parameter int DIGITS = 4
);
    localparam int c_width = 4 * DIGITS;

    logic               in_valid;
    logic               in_ready;
    logic [c_width-1:0] a;
    logic [c_width-1:0] b;
    logic               bin;
    logic               out_valid;
    logic               out_ready;
    logic [c_width-1:0] d;
    logic               bout;
`ifdef BCD_SUB_CHECK_EN
    logic               err;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, err
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, err
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout
    );
`endif
endinterface
`default_nettype wire

// File: rtl/bcd_sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : bcd_sub_serial
// Description : Digit-serial packed-BCD subtractor, D = A - B - bin, one
//               decimal digit per clock, least significant digit first.
//               A negative result sets bout and leaves the ten's-complement
//               form in d. Digits above 9 go through the same arithmetic
//               without correction.
// Ports       : clk    - clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus    - bcd_sub_serial_if.slave
//                        in_valid/in_ready, a, b, bin   (operand side)
//                        out_valid/out_ready, d, bout   (result side)
//                        err (only with BCD_SUB_CHECK_EN)
// Options     : BCD_SUB_CHECK_EN - adds err, flagging any operand digit > 9
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_sub_serial #(
    parameter int DIGITS = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    bcd_sub_serial_if.slave   bus
);

    localparam int                 c_width     = 4 * DIGITS;
    localparam int                 c_cnt_w     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(DIGITS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_borrow;
    logic [c_width-1:0]   r_a;
    logic [c_width-1:0]   r_b;
    logic [c_width-1:0]   r_d;
    logic                 r_bout;
    logic                 r_out_valid;

    // One digit step. The operand registers shift right each RUN cycle, so
    // the current digit is always in bits [3:0]. The span of a - b - borrow
    // for 4-bit digits is -16..15, which fits 5-bit two's complement exactly.
    logic [4:0]           w_t;
    logic                 w_neg;
    logic [3:0]           w_digit;

    always_comb begin
        w_t     = {1'b0, r_a[3:0]} - {1'b0, r_b[3:0]} - {4'd0, r_borrow};
        w_neg   = w_t[4];
        // Low nibble of (t + 10) depends only on the low nibble of t.
        w_digit = w_neg ? (w_t[3:0] + 4'd10) : w_t[3:0];
    end

`ifdef BCD_SUB_CHECK_EN
    logic r_err_pending;
    logic w_bad_digit;

    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) begin
                w_bad_digit = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef BCD_SUB_CHECK_EN
            r_err_pending <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // in_ready is high whenever we are here out of reset.
                    if (bus.in_valid) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= bus.bin;
                        r_cnt    <= '0;
                        r_state  <= ST_RUN;
`ifdef BCD_SUB_CHECK_EN
                        r_err_pending <= w_bad_digit;
`endif
                    end
                end

                ST_RUN: begin
                    // Digit registers are written in place so untouched
                    // digits keep their previous value.
                    r_d[{r_cnt, 2'b00} +: 4] <= w_digit;
                    r_borrow <= w_neg;
                    r_a      <= r_a >> 4;
                    r_b      <= r_b >> 4;
                    r_cnt    <= r_cnt + c_cnt_one;
                    if (r_cnt == c_last_digit) begin
                        r_bout      <= w_neg;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = rst_n & (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.d         = r_d;
    assign bus.bout      = r_bout;
`ifdef BCD_SUB_CHECK_EN
    assign bus.err       = r_out_valid & r_err_pending;
`endif

endmodule
`default_nettype wire
